// File: rtl/matvec_engine.sv
// matvec_engine: matrix-vector multiply engine.
//   Fetches B (word at base_addr) and NUM_ROWS rows of A (words at base_addr+1+r)
//   over an Avalon-MM-style read master, then computes C[r] = sum_k A[r][k]*B[k]
//   with NUM_ROWS parallel MAC lanes, one column per cycle.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, accumulate       run request; accumulate=1 keeps previous results
//   base_addr               word address of B
//   mem_address, mem_read   read master request (held stable under waitrequest)
//   mem_readdata            one row/vector word, element 0 in the MSBs
//   mem_readdatavalid       read data strobe
//   mem_waitrequest         slave stall
//   busy, done, state_out   status (state_out: IDLE=0 REQ=1 WAIT_DATA=2 CALC=3 DONE=4)
//   res_sel, res_data       combinational result readout, 0 for out-of-range rows
//   ovf                     per-row sticky overflow flags
// Optional build macro: MATVEC_SATURATE_EN (saturating accumulators + ovf flags;
// when undefined accumulators wrap and ovf is tied to 0).
module matvec_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ROWS   = 8,
    parameter int NUM_COLS   = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           accumulate,
    input  logic [31:0]                    base_addr,
    output logic [31:0]                    mem_address,
    output logic                           mem_read,
    input  logic [NUM_COLS*DATA_WIDTH-1:0] mem_readdata,
    input  logic                           mem_readdatavalid,
    input  logic                           mem_waitrequest,
    output logic                           busy,
    output logic                           done,
    output logic [2:0]                     state_out,
    input  logic [$clog2(NUM_ROWS)-1:0]    res_sel,
    output logic [ACC_WIDTH-1:0]           res_data,
    output logic [NUM_ROWS-1:0]            ovf
);

    localparam int IW = $clog2(NUM_ROWS + 1);
    localparam int KW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DATA = 3'd2,
        CALC      = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                state;
    logic [31:0]           base;
    logic [IW-1:0]         idx;
    logic [KW-1:0]         k;
    logic [DATA_WIDTH-1:0] b_elem [NUM_COLS];
    logic [DATA_WIDTH-1:0] a_elem [NUM_ROWS][NUM_COLS];
    logic [ACC_WIDTH-1:0]  acc      [NUM_ROWS];
    logic [ACC_WIDTH-1:0]  acc_next [NUM_ROWS];

    assign state_out = state;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // One MAC step per lane for the current column k.
`ifdef MATVEC_SATURATE_EN
    logic [NUM_ROWS-1:0] ovf_q;
    logic [NUM_ROWS-1:0] ovf_next;
    assign ovf = ovf_q;

    always_comb begin
        logic [2*DATA_WIDTH-1:0] prod;
        logic [ACC_WIDTH:0]      sum;
        prod     = '0;
        sum      = '0;
        ovf_next = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            prod        = a_elem[r][k] * b_elem[k];
            sum         = {1'b0, acc[r]} + (ACC_WIDTH + 1)'(prod);
            ovf_next[r] = sum[ACC_WIDTH];
            acc_next[r] = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
        end
    end
`else
    assign ovf = '0;

    always_comb begin
        logic [2*DATA_WIDTH-1:0] prod;
        prod = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            prod        = a_elem[r][k] * b_elem[k];
            acc_next[r] = acc[r] + ACC_WIDTH'(prod);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base        <= '0;
            idx         <= '0;
            k           <= '0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            for (int unsigned r = 0; r < NUM_ROWS; r++) acc[r] <= '0;
`ifdef MATVEC_SATURATE_EN
            ovf_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base        <= base_addr;
                        idx         <= '0;
                        mem_address <= base_addr;
                        mem_read    <= 1'b1;
                        if (!accumulate) begin
                            for (int unsigned r = 0; r < NUM_ROWS; r++) acc[r] <= '0;
`ifdef MATVEC_SATURATE_EN
                            ovf_q <= '0;
`endif
                        end
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        state    <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (mem_readdatavalid) begin
                        idx <= idx + 1'b1;
                        if (idx == IW'(NUM_ROWS)) begin
                            k     <= '0;
                            state <= CALC;
                        end else begin
                            mem_address <= base + 32'(idx) + 32'd1;
                            mem_read    <= 1'b1;
                            state       <= REQ;
                        end
                    end
                end
                CALC: begin
                    for (int unsigned r = 0; r < NUM_ROWS; r++) acc[r] <= acc_next[r];
`ifdef MATVEC_SATURATE_EN
                    ovf_q <= ovf_q | ovf_next;
`endif
                    k <= k + 1'b1;
                    if (k == KW'(NUM_COLS - 1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand storage needs no reset: it is always written before CALC reads it.
    always_ff @(posedge clk) begin
        if (state == WAIT_DATA && mem_readdatavalid) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                if (idx == '0)
                    b_elem[c] <= mem_readdata[(NUM_COLS-1-c)*DATA_WIDTH +: DATA_WIDTH];
                for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                    if (idx == IW'(r + 1))
                        a_elem[r][c] <= mem_readdata[(NUM_COLS-1-c)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        res_data = '0;
        if (32'(res_sel) < 32'(NUM_ROWS)) res_data = acc[res_sel];
    end

endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine: a default-size instance (ACC_WIDTH=24) and an
// ACC_WIDTH=16 instance share stimulus and memory contents, each with its own
// read-slave model (configurable waitrequest stall, readdatavalid one cycle after
// acceptance).
module tb_matvec_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        accumulate;
    logic [31:0] base_addr;
    logic [2:0]  res_sel;

    logic [31:0] a_addr, b_addr;
    logic        a_read, b_read;
    logic [63:0] a_rdata, b_rdata;
    logic        a_rdv, b_rdv;
    logic        a_wr, b_wr;
    logic        a_busy, b_busy;
    logic        a_done, b_done;
    logic [2:0]  a_state, b_state;
    logic [23:0] a_res;
    logic [15:0] b_res;
    logic [7:0]  a_ovf, b_ovf;

    logic [63:0] mem [0:63];
    int unsigned stall_n;
    int unsigned a_wcnt, b_wcnt;

    int checks = 0;
    int errors = 0;
    int busy_bad, stall_bad, stall_seen;

    always #5 clk = ~clk;

    matvec_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .accumulate(accumulate),
        .base_addr(base_addr), .mem_address(a_addr), .mem_read(a_read),
        .mem_readdata(a_rdata), .mem_readdatavalid(a_rdv), .mem_waitrequest(a_wr),
        .busy(a_busy), .done(a_done), .state_out(a_state), .res_sel(res_sel),
        .res_data(a_res), .ovf(a_ovf)
    );

    matvec_engine #(.ACC_WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .accumulate(accumulate),
        .base_addr(base_addr), .mem_address(b_addr), .mem_read(b_read),
        .mem_readdata(b_rdata), .mem_readdatavalid(b_rdv), .mem_waitrequest(b_wr),
        .busy(b_busy), .done(b_done), .state_out(b_state), .res_sel(res_sel),
        .res_data(b_res), .ovf(b_ovf)
    );

    assign a_wr = a_read && (a_wcnt < stall_n);
    assign b_wr = b_read && (b_wcnt < stall_n);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_wcnt <= 0; a_rdv <= 1'b0; a_rdata <= '0;
        end else begin
            a_rdv <= 1'b0;
            if (a_read) begin
                if (a_wcnt < stall_n) a_wcnt <= a_wcnt + 1;
                else begin a_wcnt <= 0; a_rdv <= 1'b1; a_rdata <= mem[a_addr[5:0]]; end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_wcnt <= 0; b_rdv <= 1'b0; b_rdata <= '0;
        end else begin
            b_rdv <= 1'b0;
            if (b_read) begin
                if (b_wcnt < stall_n) b_wcnt <= b_wcnt + 1;
                else begin b_wcnt <= 0; b_rdv <= 1'b1; b_rdata <= mem[b_addr[5:0]]; end
            end
        end
    end

    // Starts a run, returns edges from the start-sampling edge to the first DONE
    // sample (-1 on timeout), and checks that done drops after one cycle.
    task automatic run(input logic [31:0] base, input logic acc, output int edges);
        logic        pw;
        logic [31:0] pa;
        busy_bad = 0; stall_bad = 0; stall_seen = 0;
        edges = -1;
        base_addr = base; accumulate = acc; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            pw = a_read && a_wr;
            pa = a_addr;
            @(posedge clk); #1;
            if (pw) begin
                stall_seen++;
                if (!a_read || a_addr !== pa) stall_bad++;
            end
            if (a_busy !== 1'b1) busy_bad++;
            if (a_done === 1'b1) begin edges = n; break; end
        end
        checks++;
        if (edges < 0) begin
            errors++; $display("FAIL run_timeout: done not seen within 400 edges");
        end
        @(posedge clk); #1;
        checks++;
        if ({a_done, a_busy, a_state} !== {1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL done_pulse: done=%0b busy=%0b state=%0d, required 0 0 0", a_done, a_busy, a_state);
        end
    endtask

    task automatic load_mem;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 64'h0102030405060708;                    // B = [1..8]
        for (int r = 0; r < 8; r++) mem[1+r] = 64'h1 << ((7 - r) * 8);  // identity rows
        for (int i = 16; i < 25; i++) mem[i] = '1;        // all 0xFF
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; accumulate = 1'b0; base_addr = '0; res_sel = '0;
        stall_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({a_state, a_read, a_busy, a_done, a_ovf, a_addr} !== {3'd0, 3'b000, 8'h00, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d read=%0b busy=%0b done=%0b ovf=%h addr=%h, required all 0",
                     a_state, a_read, a_busy, a_done, a_ovf, a_addr);
        end
        for (int r = 0; r < 8; r++) begin
            res_sel = 3'(r); #1;
            checks++;
            if (a_res !== 24'h0) begin
                errors++; $display("FAIL reset_res row %0d: got %h required 000000", r, a_res);
            end
        end
    endtask

    task automatic test_identity;
        int e;
        run(32'd0, 1'b0, e);
        checks++;
        if (e !== 26) begin errors++; $display("FAIL identity_latency: got %0d required 26", e); end
        for (int r = 0; r < 8; r++) begin
            res_sel = 3'(r); #1;
            checks++;
            if (a_res !== 24'(r + 1)) begin
                errors++; $display("FAIL identity_res row %0d: got %0d required %0d", r, a_res, r + 1);
            end
        end
        checks++;
        if (a_ovf !== 8'h00) begin errors++; $display("FAIL identity_ovf: got %h required 00", a_ovf); end
    endtask

    task automatic test_all_ff;
        int e;
        logic [15:0] exp16;
        logic [7:0]  expovf;
`ifdef MATVEC_SATURATE_EN
        exp16 = 16'hFFFF; expovf = 8'hFF;
`else
        exp16 = 16'hF008; expovf = 8'h00;
`endif
        run(32'd16, 1'b0, e);
        checks++;
        if (e !== 26) begin errors++; $display("FAIL allff_latency: got %0d required 26", e); end
        checks++;
        if (busy_bad !== 0) begin errors++; $display("FAIL allff_busy: %0d low samples, required 0", busy_bad); end
        for (int r = 0; r < 8; r++) begin
            res_sel = 3'(r); #1;
            checks++;
            if (a_res !== 24'h07F008) begin
                errors++; $display("FAIL allff_res24 row %0d: got %h required 07f008", r, a_res);
            end
            checks++;
            if (b_res !== exp16) begin
                errors++; $display("FAIL allff_res16 row %0d: got %h required %h", r, b_res, exp16);
            end
        end
        checks++;
        if (a_ovf !== 8'h00) begin errors++; $display("FAIL allff_ovf24: got %h required 00", a_ovf); end
        checks++;
        if (b_ovf !== expovf) begin errors++; $display("FAIL allff_ovf16: got %h required %h", b_ovf, expovf); end
    endtask

    task automatic test_waitrequest;
        int e;
        stall_n = 5;
        run(32'd0, 1'b0, e);
        stall_n = 0;
        checks++;
        if (e !== 71) begin errors++; $display("FAIL stall_latency: got %0d required 71", e); end
        checks++;
        if (stall_seen !== 45) begin errors++; $display("FAIL stall_cycles: got %0d required 45", stall_seen); end
        checks++;
        if (stall_bad !== 0) begin errors++; $display("FAIL stall_stable: %0d unstable cycles, required 0", stall_bad); end
        for (int r = 0; r < 8; r++) begin
            res_sel = 3'(r); #1;
            checks++;
            if (a_res !== 24'(r + 1)) begin
                errors++; $display("FAIL stall_res row %0d: got %0d required %0d", r, a_res, r + 1);
            end
        end
    endtask

    task automatic test_accumulate;
        int e;
        run(32'd0, 1'b0, e);
        run(32'd0, 1'b1, e);
        for (int r = 0; r < 8; r++) begin
            res_sel = 3'(r); #1;
            checks++;
            if (a_res !== 24'(2 * (r + 1))) begin
                errors++; $display("FAIL accum_res row %0d: got %0d required %0d", r, a_res, 2 * (r + 1));
            end
        end
        run(32'd0, 1'b0, e);
        for (int r = 0; r < 8; r++) begin
            res_sel = 3'(r); #1;
            checks++;
            if (a_res !== 24'(r + 1)) begin
                errors++; $display("FAIL accum_clear row %0d: got %0d required %0d", r, a_res, r + 1);
            end
        end
    endtask

    task automatic test_reset_mid;
        int e;
        int done_seen;
        base_addr = 32'd16; accumulate = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (a_state !== 3'd3) begin errors++; $display("FAIL midrst_in_calc: state=%0d required 3", a_state); end
        rst_n = 1'b0; #2;
        checks++;
        if ({a_state, a_read, a_busy, a_done} !== {3'd0, 3'b000}) begin
            errors++;
            $display("FAIL midrst_outputs: state=%0d read=%0b busy=%0b done=%0b, required 0", a_state, a_read, a_busy, a_done);
        end
        for (int r = 0; r < 8; r++) begin
            res_sel = 3'(r); #1;
            checks++;
            if (a_res !== 24'h0) begin errors++; $display("FAIL midrst_res row %0d: got %h required 000000", r, a_res); end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (a_done !== 1'b0 || a_state !== 3'd0) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done: %0d active samples, required 0", done_seen); end
        run(32'd0, 1'b0, e);
        checks++;
        if (e !== 26) begin errors++; $display("FAIL midrst_rerun_latency: got %0d required 26", e); end
        for (int r = 0; r < 8; r++) begin
            res_sel = 3'(r); #1;
            checks++;
            if (a_res !== 24'(r + 1)) begin
                errors++; $display("FAIL midrst_rerun row %0d: got %0d required %0d", r, a_res, r + 1);
            end
        end
    endtask

    initial begin
        load_mem();
        test_reset();
        test_identity();
        test_all_ff();
        test_waitrequest();
        test_accumulate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matvec_engine.md
Name: matvec_engine

Overview:
Parametrised matrix-vector multiply engine: fetches one B vector and NUM_ROWS rows of A from word-addressed memory over an Avalon-MM-style read master, then computes C[r] = sum_k A[r][k]*B[k] with NUM_ROWS parallel MACs, one column per cycle. It has a start/busy/done handshake, a selectable result readout and an optional accumulate-across-runs mode. It sits between the board-level memory wrapper and the HEX/LED display logic. It replaces the fixed 8x8 fetch/FIFO/MAC datapath.

Parameters:
DATA_WIDTH, 8, element width in bits (unsigned)
NUM_ROWS, 8, rows of A = number of MAC lanes / results
NUM_COLS, 8, columns of A = length of B = elements per memory word
ACC_WIDTH, 24, accumulator/result width in bits (must be >= 2*DATA_WIDTH)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
accumulate  in  1  sampled with start; 1 = keep accumulators, 0 = clear them
base_addr  in  32  word address of B; row r of A is at base_addr+1+r
mem_address  out  32  read address
mem_read  out  1  read request
mem_readdata  in  NUM_COLS*DATA_WIDTH  read data; element 0 in the most-significant DATA_WIDTH bits
mem_readdatavalid  in  1  read data valid
mem_waitrequest  in  1  slave stall
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion
state_out  out  3  current state encoding, for LEDR
res_sel  in  $clog2(NUM_ROWS)  result row select
res_data  out  ACC_WIDTH  C[res_sel], combinational from the accumulator registers
ovf  out  NUM_ROWS  per-row sticky overflow flags

Behaviour:
- Reset (async, rst_n=0): state IDLE, all accumulators 0, word index 0, mem_read 0, mem_address 0, done 0, busy 0, ovf 0. A reset during any state aborts the run immediately.
- States and state_out encoding: IDLE=0, REQ=1, WAIT_DATA=2, CALC=3, DONE=4.
- IDLE: when start=1, latch base_addr, set word index to 0, clear the accumulators and ovf if accumulate=0, then go to REQ. Start is ignored in every other state.
- REQ: mem_read=1, mem_address=base+index. Address and read stay stable while mem_waitrequest=1. When mem_read=1 and mem_waitrequest=0 at a clock edge, the request is accepted and the FSM goes to WAIT_DATA. Only one request is outstanding at a time.
- WAIT_DATA: mem_read=0. On mem_readdatavalid=1, capture the word: index 0 goes to the B register, index r+1 goes to A row r. Then increment the index. If the index was NUM_ROWS, go to CALC; otherwise go back to REQ. readdatavalid in any other state is ignored.
- CALC: NUM_COLS cycles, column counter k=0..NUM_COLS-1. Every lane r does acc[r] += A[r][k]*B[k]. The product is 2*DATA_WIDTH bits unsigned, zero-extended, and wraps modulo 2^ACC_WIDTH. After k=NUM_COLS-1, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Results persist until the next start with accumulate=0, or until reset.
- Latency: with waitrequest=0 and readdatavalid arriving the cycle after acceptance, the FSM is in DONE exactly 2*(NUM_ROWS+1)+NUM_COLS clock edges after the edge that samples start (26 for defaults).
- res_sel >= NUM_ROWS returns res_data=0.
- mem_waitrequest held high indefinitely: the FSM stays in REQ with stable outputs. No timeout.

Optional Feature:
MATVEC_SATURATE_EN.
- Defined: an accumulate that would exceed 2^ACC_WIDTH-1 clamps to all-ones, and ovf[r] sets (sticky until cleared by a start with accumulate=0, or by reset).
- Undefined: accumulators wrap and ovf is tied to 0.

Test Plan:
- Identity A, B=[1..8], defaults, waitrequest=0 -> done pulse at edge 26 after start; res_data for rows 0..7 = 1..8; ovf=0.
- All elements 0xFF -> every res_data = 8*255*255 = 0x07F008; busy high from REQ through DONE, low after.
- mem_waitrequest=1 for 5 cycles on each request -> mem_address/mem_read stable while stalled; done arrives 45 edges later than nominal; results unchanged.
- Identity A, B=[1..8], run once, then run again with accumulate=1 -> row r = 2*(r+1); a third run with accumulate=0 -> back to r+1.
- rst_n pulsed low during CALC -> state_out=0, mem_read=0, all res_data=0, no done pulse; a following start completes normally.
- ACC_WIDTH=16, all elements 0xFF, with MATVEC_SATURATE_EN -> res_data=0xFFFF and ovf=all ones; without the macro -> res_data=0xF008 and ovf=0.
